// File: rtl/zbt_bank_sched.sv
// Single-bank ZBT scheduler: display reads take priority, edge-processor writes are
// buffered in a FIFO and drained in idle slots or forced after a bounded read streak.
module zbt_bank_sched #(
  parameter int FIFO_AW       = 3,
  parameter int MAX_RD_STREAK = 16,
  parameter int MEM_LATENCY   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_req,
  input  logic [18:0]        rd_addr,
  output logic               rd_ready,
  output logic [35:0]        rd_data,
  output logic               rd_valid,
  input  logic               wr_valid,
  input  logic [18:0]        wr_addr,
  input  logic [35:0]        wr_data,
  output logic               wr_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [18:0]        mem_addr,
  output logic               mem_we,
  output logic [35:0]        mem_wdata,
  input  logic [35:0]        mem_rdata
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int SW    = $clog2(MAX_RD_STREAK + 1);

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_READ  = 2'd1,
    G_WRITE = 2'd2
  } grant_t;

  logic [FIFO_AW:0]   r_level;
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [18:0]        r_fifo_addr [DEPTH];
  logic [35:0]        r_fifo_data [DEPTH];
  logic [SW-1:0]      r_streak;

  logic [18:0]        r_mem_addr;
  logic               r_mem_we;
  logic [35:0]        r_mem_wdata;
  logic [35:0]        r_rd_data;
  logic               r_rd_valid;

  logic               r_wd_v  [MEM_LATENCY];
  logic [35:0]        r_wd    [MEM_LATENCY];
  logic               r_tag   [MEM_LATENCY+1];

  grant_t             w_grant;
  logic               w_empty;
  logic               w_full;
  logic               w_forced;
  logic               w_push;
  logic               w_pop;

  assign w_empty  = (r_level == {(FIFO_AW+1){1'b0}});
  assign w_full   = (r_level == (FIFO_AW+1)'(DEPTH));
  assign w_forced = (r_streak == SW'(MAX_RD_STREAK)) && !w_empty;

  // Grant decision from registered state only; a same-cycle push never qualifies.
  always_comb begin
    w_grant = G_IDLE;
    if (reset) begin
      w_grant = G_IDLE;
    end else if (w_forced) begin
      w_grant = G_WRITE;
    end else if (rd_req) begin
      w_grant = G_READ;
    end else if (!w_empty) begin
      w_grant = G_WRITE;
    end else begin
      w_grant = G_IDLE;
    end
  end

  assign rd_ready = (w_grant == G_READ);
  assign wr_ready = !w_full && !reset;
  assign w_push   = wr_valid && wr_ready;
  assign w_pop    = (w_grant == G_WRITE);

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= {(FIFO_AW+1){1'b0}};
      r_wptr  <= {FIFO_AW{1'b0}};
      r_rptr  <= {FIFO_AW{1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage; contents are don't-care outside the occupied window.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= wr_addr;
      r_fifo_data[r_wptr] <= wr_data;
    end
  end

  // Consecutive-read streak seen by a waiting write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= {SW{1'b0}};
    end else if (w_empty || w_grant == G_WRITE) begin
      r_streak <= {SW{1'b0}};
    end else if (w_grant == G_READ && r_streak != SW'(MAX_RD_STREAK)) begin
      r_streak <= r_streak + 1'b1;
    end else begin
      r_streak <= r_streak;
    end
  end

  // Address/command register; IDLE keeps the last address on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_addr <= 19'd0;
      r_mem_we   <= 1'b0;
    end else begin
      case (w_grant)
        G_READ: begin
          r_mem_addr <= rd_addr;
          r_mem_we   <= 1'b0;
        end
        G_WRITE: begin
          r_mem_addr <= r_fifo_addr[r_rptr];
          r_mem_we   <= 1'b1;
        end
        default: begin
          r_mem_addr <= r_mem_addr;
          r_mem_we   <= 1'b0;
        end
      endcase
    end
  end

  // Write data trails its address by the ZBT pipeline depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        r_wd_v[i] <= 1'b0;
        r_wd[i]   <= 36'd0;
      end
      r_mem_wdata <= 36'd0;
    end else begin
      r_wd_v[0] <= w_pop;
      r_wd[0]   <= w_pop ? r_fifo_data[r_rptr] : r_wd[0];
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_wd_v[i] <= r_wd_v[i-1];
        r_wd[i]   <= r_wd[i-1];
      end
      if (r_wd_v[MEM_LATENCY-1]) r_mem_wdata <= r_wd[MEM_LATENCY-1];
      else                       r_mem_wdata <= r_mem_wdata;
    end
  end

  // Read tags follow each issued read until its data is on mem_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= MEM_LATENCY; i++) r_tag[i] <= 1'b0;
      r_rd_data  <= 36'd0;
      r_rd_valid <= 1'b0;
    end else begin
      r_tag[0] <= (w_grant == G_READ);
      for (int i = 1; i <= MEM_LATENCY; i++) r_tag[i] <= r_tag[i-1];
      r_rd_valid <= r_tag[MEM_LATENCY];
      if (r_tag[MEM_LATENCY]) r_rd_data <= mem_rdata;
      else                    r_rd_data <= r_rd_data;
    end
  end

  assign fifo_level = r_level;
  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_zbt_bank_sched.sv
// Scoreboard bench for zbt_bank_sched: handshakes push expectations, a negedge monitor
// pops and compares them against memory-side and read-return activity.
module tb_zbt_bank_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [18:0] rd_addr;
  logic        rd_ready;
  logic [35:0] rd_data;
  logic        rd_valid;
  logic        wr_valid;
  logic [18:0] wr_addr;
  logic [35:0] wr_data;
  logic        wr_ready;
  logic [3:0]  fifo_level;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [35:0] mem_wdata;
  logic [35:0] mem_rdata;

  zbt_bank_sched #(.FIFO_AW(3), .MAX_RD_STREAK(16), .MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .fifo_level(fifo_level),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ZBT model: read data appears two cycles after its address is on the bus
  function automatic logic [35:0] mem_f(input logic [18:0] a);
    if (a == 19'h00123) return 36'hABCDE1234;
    return {a[17:0], ~a[17:0]};
  endfunction

  logic [18:0] ad1, ad2;
  always @(posedge clk) begin
    ad1 <= mem_addr;
    ad2 <= ad1;
  end
  assign mem_rdata = mem_f(ad2);

  typedef struct { logic [35:0] d; int c; } tq_t;
  typedef struct { logic [18:0] a; logic [35:0] d; } wq_t;
  tq_t q_rd[$];
  tq_t q_wd[$];
  wq_t q_wr[$];

  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_gap = 1'b0;
  bit   t5 = 1'b0;
  int   last_we = -1;
  logic prev_wr_ready = 1'b0;
  logic pend_ra_v = 1'b0;
  logic [18:0] pend_ra = 19'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor: compare pending expectations, then record this cycle's handshakes
  always @(negedge clk) begin
    tq_t r;
    wq_t w;
    if (pend_ra_v) begin
      chk("rd_mem_addr", 64'(mem_addr), 64'(pend_ra));
      chk("rd_mem_we", 64'(mem_we), 64'd0);
    end
    if (rd_valid === 1'b1) begin
      if (q_rd.size() == 0) flag("unexpected_rd_valid: got rd_valid=1 expected 0");
      else begin
        r = q_rd.pop_front();
        chk("rd_data", 64'(rd_data), 64'(r.d));
        chk("rd_latency", 64'(cyc - r.c), 64'd4);
      end
    end
    if (mem_we === 1'b1) begin
      if (q_wr.size() == 0) flag("unexpected_mem_we: got mem_we=1 expected 0");
      else begin
        w = q_wr.pop_front();
        chk("wr_mem_addr", 64'(mem_addr), 64'(w.a));
        q_wd.push_back('{w.d, cyc + 2});
      end
      if (chk_gap && last_we >= 0) chk("write_gap", 64'(cyc - last_we), 64'd17);
      last_we = cyc;
      if (t5) begin
        chk("wr_ready_after_pop", 64'(wr_ready), 64'd1);
        chk("wr_ready_at_pop", 64'(prev_wr_ready), 64'd0);
      end
    end else if (t5) begin
      chk("wr_ready_full", 64'(wr_ready), 64'd0);
    end
    if (q_wd.size() > 0 && q_wd[0].c == cyc) begin
      r = q_wd.pop_front();
      chk("mem_wdata", 64'(mem_wdata), 64'(r.d));
    end
    prev_wr_ready = wr_ready;
    pend_ra_v = rd_req && rd_ready && !reset;
    pend_ra   = rd_addr;
    if (rd_req === 1'b1 && rd_ready === 1'b1) q_rd.push_back('{mem_f(rd_addr), cyc});
    if (wr_valid === 1'b1 && wr_ready === 1'b1) q_wr.push_back('{wr_addr, wr_data});
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    logic [18:0] wa;
    reset = 1'b1; rd_req = 1'b1; rd_addr = 19'd0;
    wr_valid = 1'b1; wr_addr = 19'd0; wr_data = 36'd0;

    // reset held 3 cycles with requests asserted
    repeat (3) begin
      @(posedge clk); #1;
      chk("rd_ready_in_reset", 64'(rd_ready), 64'd0);
      chk("wr_ready_in_reset", 64'(wr_ready), 64'd0);
    end
    reset = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
    @(posedge clk); #1;
    chk("reset_mem_we", 64'(mem_we), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_fifo_level", 64'(fifo_level), 64'd0);
    chk("reset_wr_ready", 64'(wr_ready), 64'd1);

    // single read
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 19'h00123;
    #1 chk("rd_ready_idle", 64'(rd_ready), 64'd1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    repeat (6) @(posedge clk);

    // eight writes with no reads, drained in idle slots
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_addr = 19'(i); wr_data = 36'(i);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("drain_level", 64'(fifo_level), 64'd0);

    // reads held; eight writes preloaded, forced one every 17 cycles
    last_we = -1; chk_gap = 1'b1;
    rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = 19'h00100 + 19'(i); wr_data = 36'h000F00000 + 36'(i);
      rd_addr = 19'h40000 + 19'(i);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 75; i++) begin
      rd_addr = 19'h41000 + 19'(i);
      @(posedge clk); #1;
    end

    // writer held too: FIFO fills, each forced pop frees one slot for one cycle
    wa = 19'h00200;
    wr_valid = 1'b1; wr_addr = wa; wr_data = {17'h1, wa};
    for (int i = 0; i < 70; i++) begin
      rd_addr = 19'h42000 + 19'(i);
      @(negedge clk);
      acc = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (acc) begin
        wa = wa + 19'd1;
        wr_addr = wa; wr_data = {17'h1, wa};
      end
      if (fifo_level == 4'd8) t5 = 1'b1;
    end
    chk("full_reached", 64'(t5), 64'd1);
    t5 = 1'b0; chk_gap = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("drain2_level", 64'(fifo_level), 64'd0);
    chk("wr_queue_empty", 64'(q_wr.size()), 64'd0);
    chk("rd_queue_empty", 64'(q_rd.size()), 64'd0);

    // reset one cycle after a read grant, with a write sitting in the FIFO
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 19'h05555;
    wr_valid = 1'b1; wr_addr = 19'h07000; wr_data = 36'h000000001;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_valid = 1'b0; reset = 1'b1;
    q_rd.delete();
    q_wr.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_level", 64'(fifo_level), 64'd0);
    chk("rst_mid_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mid_rd_valid", 64'(rd_valid), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("rst_mid_level_after", 64'(fifo_level), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
